// File: rtl/point_stream_parser.sv
// ASCII "X,Y" line parser that turns each decimal pair into a 64-bit point word
// for the point RAM. Optional CR tolerance: define POINT_STREAM_PARSER_CRLF_EN.
module point_stream_parser #(
  parameter int MAX_POINTS = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [63:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              out_ready,
  output logic [ADDR_W:0]   point_count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {S_X, S_Y, S_END, S_STOP} state_e;
  typedef enum logic [1:0] {
    E_NONE     = 2'd0,
    E_SYNTAX   = 2'd1,
    E_OVERFLOW = 2'd2,
    E_CAPACITY = 2'd3
  } err_e;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
`ifdef POINT_STREAM_PARSER_CRLF_EN
  localparam logic [7:0] CH_CR    = 8'h0D;
`endif
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_POINTS);

  state_e            state, state_nxt;
  logic [31:0]       acc_x, acc_x_nxt, acc_y, acc_y_nxt;
  logic              x_seen, x_seen_nxt, y_seen, y_seen_nxt;
  logic              out_valid_nxt;
  logic [63:0]       out_data_nxt;
  logic [ADDR_W-1:0] out_addr_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              done_nxt, err_nxt;
  err_e              code_nxt, fault;

  logic              accept, is_digit, complete;
  logic [3:0]        digit;
  logic [31:0]       acc_cur;
  logic [35:0]       acc_wide;
  logic [ADDR_W:0]   total;

  assign in_ready = !rst && (state == S_X || state == S_Y) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_digit = (in_data >= CH_0) && (in_data <= CH_9);
  assign digit    = in_data[3:0];
  assign acc_cur  = (state == S_Y) ? acc_y : acc_x;
  // acc*10 as shifts; 36 bits holds (2^32-1)*10+9, so overflow is visible in the top nibble.
  assign acc_wide = ({4'd0, acc_cur} << 3) + ({4'd0, acc_cur} << 1) + {32'd0, digit};
  // Points already handed downstream plus the one sitting in the output register.
  assign total    = point_count + {{ADDR_W{1'b0}}, out_valid};

  always_comb begin
    // NOTE: every value written here gets a default first so no path can infer a latch.
    state_nxt     = state;
    acc_x_nxt     = acc_x;
    acc_y_nxt     = acc_y;
    x_seen_nxt    = x_seen;
    y_seen_nxt    = y_seen;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_addr_nxt  = out_addr;
    count_nxt     = point_count;
    done_nxt      = done;
    err_nxt       = err;
    code_nxt      = err_e'(err_code);
    fault         = E_NONE;
    complete      = 1'b0;

    if (out_valid && out_ready) begin
      out_valid_nxt = 1'b0;
      count_nxt     = point_count + (ADDR_W+1)'(1);
    end

    if (accept) begin
      if (is_digit) begin
        if (acc_wide[35:32] != 4'd0) begin
          fault = E_OVERFLOW;
        end else if (state == S_X) begin
          acc_x_nxt  = acc_wide[31:0];
          x_seen_nxt = 1'b1;
        end else begin
          acc_y_nxt  = acc_wide[31:0];
          y_seen_nxt = 1'b1;
        end
      end else if (in_data == CH_COMMA) begin
        if (state == S_X && x_seen) begin
          state_nxt  = S_Y;
          acc_y_nxt  = '0;
          y_seen_nxt = 1'b0;
        end else begin
          fault = E_SYNTAX;
        end
      end else if (in_data == CH_LF) begin
        if (state == S_Y && y_seen) begin
          complete = 1'b1;
        end else if (!(state == S_X && !x_seen)) begin
          fault = E_SYNTAX;
        end
`ifdef POINT_STREAM_PARSER_CRLF_EN
      end else if (in_data != CH_CR) begin
        fault = E_SYNTAX;
      end
`else
      end else begin
        fault = E_SYNTAX;
      end
`endif

      // End of stream may close a line that had no trailing LF.
      if (fault == E_NONE && in_last && !complete) begin
        if (state_nxt == S_Y && y_seen_nxt) begin
          complete = 1'b1;
        end else if (state_nxt == S_Y || x_seen_nxt) begin
          fault = E_SYNTAX;
        end
      end

      if (fault == E_NONE && complete) begin
        if (total == MAX_CNT) begin
          fault = E_CAPACITY;
        end else begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = {acc_x_nxt, acc_y_nxt};
          out_addr_nxt  = total[ADDR_W-1:0];
          state_nxt     = S_X;
          acc_x_nxt     = '0;
          acc_y_nxt     = '0;
          x_seen_nxt    = 1'b0;
          y_seen_nxt    = 1'b0;
        end
      end

      if (fault != E_NONE) begin
        err_nxt   = 1'b1;
        code_nxt  = fault;
        done_nxt  = 1'b1;
        state_nxt = S_STOP;
      end else if (in_last) begin
        state_nxt = S_END;
        done_nxt  = !out_valid_nxt;
      end
    end else if (state == S_END && !out_valid_nxt) begin
      done_nxt  = 1'b1;
      state_nxt = S_STOP;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state       <= S_X;
      acc_x       <= '0;
      acc_y       <= '0;
      x_seen      <= 1'b0;
      y_seen      <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_addr    <= '0;
      point_count <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= E_NONE;
    end else begin
      state       <= state_nxt;
      acc_x       <= acc_x_nxt;
      acc_y       <= acc_y_nxt;
      x_seen      <= x_seen_nxt;
      y_seen      <= y_seen_nxt;
      out_valid   <= out_valid_nxt;
      out_data    <= out_data_nxt;
      out_addr    <= out_addr_nxt;
      point_count <= count_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      err_code    <= code_nxt;
    end
  end

endmodule

// File: tb/tb_point_stream_parser.sv
// Directed scoreboard bench for point_stream_parser; a second instance with
// MAX_POINTS=2 covers the capacity limit.
module tb_point_stream_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;

  logic        in_ready, out_valid, done, err;
  logic [63:0] out_data;
  logic [9:0]  out_addr;
  logic [10:0] point_count;
  logic [1:0]  err_code;

  logic        c_in_ready, c_out_valid, c_done, c_err;
  logic [63:0] c_out_data;
  logic [0:0]  c_out_addr;
  logic [1:0]  c_point_count;
  logic [1:0]  c_err_code;

  logic        mon_ready, mon_valid, mon_done, mon_err;
  logic [63:0] mon_data;
  logic [9:0]  mon_addr;
  logic [10:0] mon_count;
  logic [1:0]  mon_code;

  typedef struct {
    logic [9:0]  addr;
    logic [63:0] data;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t item;
  int n_checks = 0;
  int n_fail   = 0;

  point_stream_parser dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .out_ready(out_ready), .point_count(point_count), .done(done), .err(err),
    .err_code(err_code)
  );

  point_stream_parser #(.MAX_POINTS(2), .ADDR_W(1)) dut_cap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_addr(c_out_addr), .out_ready(out_ready), .point_count(c_point_count),
    .done(c_done), .err(c_err), .err_code(c_err_code)
  );

  always #5 clk = ~clk;

  always_comb begin
    mon_ready = sel ? c_in_ready  : in_ready;
    mon_valid = sel ? c_out_valid : out_valid;
    mon_done  = sel ? c_done      : done;
    mon_err   = sel ? c_err       : err;
    mon_data  = sel ? c_out_data  : out_data;
    mon_addr  = sel ? {9'd0, c_out_addr}    : out_addr;
    mon_count = sel ? {9'd0, c_point_count} : point_count;
    mon_code  = sel ? c_err_code  : err_code;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int addr, input logic [31:0] x, input logic [31:0] y);
    sb_item_t it;
    it.addr = 10'(addr);
    it.data = {x, y};
    sb.push_back(it);
  endtask

  // Handshakes are sampled on the falling edge, between driver updates.
  always @(negedge clk) begin
    if (!rst && mon_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL sb_extra: observed point %h@%0d expected none", mon_data, mon_addr);
      end else begin
        item = sb.pop_front();
        check("sb_data", mon_data, item.data);
        check("sb_addr", 64'(mon_addr), 64'(item.addr));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last, input bit may_stop, output int sent);
    sent = 0;
    for (int i = 0; i < s.len(); i++) begin
      int  waited = 0;
      bit  took   = 1'b0;
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = last && (i == s.len() - 1);
      while (!took && waited < 40) begin
        @(negedge clk);
        if (mon_ready) took = 1'b1;
        @(posedge clk); #1;
        waited++;
      end
      if (!took) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!may_stop) check("byte_accept_timeout", 64'(took), 64'd1);
        return;
      end
      sent++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mon_done && w < 100);
    check(tag, 64'(mon_done), 64'd1);
  endtask

  task automatic check_final(input string tag, input int count, input bit e, input int code);
    @(negedge clk);
    check({tag, "_count"}, 64'(mon_count), 64'(count));
    check({tag, "_err"}, 64'(mon_err), 64'(e));
    check({tag, "_code"}, 64'(mon_code), 64'(code));
    check({tag, "_in_ready"}, 64'(mon_ready), 64'd0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int sent, sent2;

    // Reset values, observed while rst is still high.
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_count", 64'(point_count), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_code", 64'(err_code), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Three LF-terminated points.
    push(0, 7, 1); push(1, 11, 1); push(2, 2, 5);
    send_str("7,1\n11,1\n2,5\n", 1'b1, 1'b0, sent);
    wait_done("basic_done");
    check_final("basic", 3, 1'b0, 0);

    // Downstream stall after the first point.
    do_reset();
    out_ready = 1'b0;
    push(0, 7, 1); push(1, 11, 1); push(2, 2, 5);
    fork
      send_str("7,1\n11,1\n2,5\n", 1'b1, 1'b0, sent);
      begin
        int w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!out_valid && w < 50);
        check("stall_first_valid", 64'(out_valid), 64'd1);
        repeat (5) begin
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_hold_data", out_data, {32'd7, 32'd1});
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_done("stall_done");
    check_final("stall", 3, 1'b0, 0);

    // Largest 32-bit X, no trailing LF.
    do_reset();
    push(0, 32'hFFFF_FFFF, 3);
    send_str("4294967295,3", 1'b1, 1'b0, sent);
    wait_done("max_done");
    check_final("max", 1, 1'b0, 0);

    // One past the 32-bit range overflows on the tenth byte.
    do_reset();
    send_str("4294967296,1\n", 1'b0, 1'b1, sent);
    check("ovf_bytes", 64'(sent), 64'd10);
    wait_done("ovf_done");
    check_final("ovf", 0, 1'b1, 2);

    // Double comma is a syntax error.
    do_reset();
    send_str("5,,6\n", 1'b1, 1'b1, sent);
    check("comma_bytes", 64'(sent), 64'd3);
    wait_done("comma_done");
    check_final("comma", 0, 1'b1, 1);

    // Blank lines are ignored.
    do_reset();
    push(0, 3, 4);
    send_str("\n\n3,4\n", 1'b1, 1'b0, sent);
    wait_done("blank_done");
    check_final("blank", 1, 1'b0, 0);

    // Stream ending in the middle of X: earlier point still delivered.
    do_reset();
    push(0, 8, 9);
    send_str("8,9\n5", 1'b1, 1'b0, sent);
    wait_done("partial_done");
    check_final("partial", 1, 1'b1, 1);

    // Capacity of two points on the small instance.
    sel = 1'b1;
    do_reset();
    push(0, 1, 1); push(1, 2, 2);
    send_str("1,1\n2,2\n3,3\n", 1'b1, 1'b1, sent);
    check("cap_bytes", 64'(sent), 64'd12);
    wait_done("cap_done");
    check_final("cap", 2, 1'b1, 3);
    sel = 1'b0;

    // CR handling depends on the build option.
    do_reset();
`ifdef POINT_STREAM_PARSER_CRLF_EN
    push(0, 1, 2);
    send_str("1,2\r\n", 1'b1, 1'b0, sent2);
    wait_done("crlf_done");
    check_final("crlf", 1, 1'b0, 0);
`else
    send_str("1,2\r\n", 1'b1, 1'b1, sent2);
    check("cr_bytes", 64'(sent2), 64'd4);
    wait_done("cr_done");
    check_final("cr", 0, 1'b1, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/point_stream_parser.md
Name: point_stream_parser

Overview:
- Upstream input stage for the day-9 rectangle search.
- Consumes the puzzle input as an ASCII byte stream, one "X,Y" pair of unsigned decimals per line.
- Emits each pair as one 64-bit point word {X[31:0], Y[31:0]} with a sequential write address, ready to load the point RAM that the max-area search engine scans.
- Reports point count, completion and sticky error status.

Parameters:
- MAX_POINTS, 1024, capacity of the downstream point RAM in points.
- ADDR_W, 10, point address width; ADDR_W >= clog2(MAX_POINTS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input byte valid
- in_data  in  8  ASCII byte
- in_last  in  1  qualifies the final byte of the stream
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_valid  out  1  point word valid
- out_data  out  64  {X, Y}
- out_addr  out  ADDR_W  point index, 0-based
- out_ready  in  1  downstream accepts the point
- point_count  out  ADDR_W+1  points emitted (handshaken) so far
- done  out  1  stream fully processed or stopped on error; sticky
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 syntax, 2 numeric overflow, 3 capacity exceeded

Behaviour:
- Reset values: in_ready 0 in the reset cycle; out_valid 0; out_data 0; out_addr 0; point_count 0; done 0; err 0; err_code 0.
- Reset mid-stream discards the partial line and any pending point.
- States:
  - S_X: accumulate X.
  - S_Y: accumulate Y.
  - S_END: wait for the final output handshake, then set done.
  - S_STOP: terminal; done=1, in_ready=0.
- in_ready = (state is S_X or S_Y) && (!out_valid || out_ready).
- Output register is single-entry:
  - out_valid rises the cycle after the accepted terminating byte.
  - It holds with stable out_data/out_addr until out_ready.
  - point_count increments on each handshake.
- Digit '0'..'9':
  - acc <= acc*10 + digit, computed 36-bit wide.
  - If the result exceeds 2^32-1: err_code 2, go to S_STOP.
  - Sets the field's digit-seen flag.
- ',' in S_X with X digits seen: go to S_Y, clear Y acc. Otherwise: err_code 1.
- LF (0x0A):
  - In S_X with no digits seen (blank line): ignored.
  - In S_Y with Y digits seen: completes the point, emit, return to S_X, clear accumulators and flags.
  - Any other LF: err_code 1.
- Any other byte: err_code 1.
- in_last on an accepted byte:
  - Process the byte first.
  - If the state is then S_Y with Y digits seen, complete and emit the pending point (no trailing LF needed).
  - If the state is then S_X with digits seen, or S_Y with no Y digits: err_code 1.
  - On success, go to S_END; done asserts the cycle after the final handshake, or the cycle after in_last if nothing is pending.
- Capacity: if a point completes while (emitted + pending) == MAX_POINTS, it is not emitted; err_code 3, go to S_STOP. A pending valid point is still delivered.
- Any error: err=1, err_code latched (first error wins), done=1 next cycle, in_ready=0 until rst. A pending point is still delivered.
- out_addr equals point_count at point creation; no wrap (capacity check precedes wrap).

Optional Feature:
- Macro: POINT_STREAM_PARSER_CRLF_EN.
- Defined: CR (0x0D) is accepted and ignored anywhere, so CRLF files parse identically to LF files.
- Undefined: CR is a syntax error (err_code 1).

Test Plan:
- "7,1\n11,1\n2,5\n" with in_last on the final LF, out_ready=1 -> points {7,1}@0, {11,1}@1, {2,5}@2; point_count 3; done=1; err=0.
- Same stream, out_ready low 5 cycles after the first point -> in_ready=0 while stalled; out_data held at {7,1}; no bytes lost; same final result.
- "4294967295,3" with in_last on '3', no LF -> {FFFFFFFF,3}@0; done=1. Then "4294967296,1\n" after reset -> err=1, err_code 2, no point emitted.
- "5,,6\n" -> err_code 1 on the second ','; in_ready=0; done=1. Also "\n\n3,4\n" -> blank lines ignored, single point {3,4}@0.
- MAX_POINTS=2, stream "1,1\n2,2\n3,3\n" -> two points emitted, err_code 3 on the third LF, point_count 2.
- "1,2\r\n" -> CRLF_EN defined: {1,2}@0; undefined: err_code 1 at CR.
